elm_layer_sched: RTL and testbench
==================================

Name: elm_layer_sched

Overview:
- Frame scheduler for one hidden/output layer of neuron instances.
- Accepts an input feature vector over a valid/ready stream and buffers it whole.
- Broadcasts the vector to all neurons as one gap-free burst, since each neuron detects end-of-vector from the falling edge of its input valid.
- Collects every neuron's activation, then streams the results out with an arg-max index.

Parameters:
- DATA_WIDTH, 16, width of input features and of the neuron input bus.
- OUT_WIDTH, 8, width of one neuron activation output (ROM output width).
- NUM_INPUTS, 128, features per frame; equals neuron numWeight.
- NUM_NEURONS, 32, neurons in the layer.
- TIMEOUT, 1024, maximum cycles spent in WAIT before giving up.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  input feature.
- in_valid  in  1  feature valid.
- in_ready  out  1  scheduler can accept a feature.
- nrn_in_data  out  DATA_WIDTH  feature broadcast to all neurons.
- nrn_in_valid  out  1  broadcast valid (neuron myinputValid).
- nrn_out  in  NUM_NEURONS*OUT_WIDTH  flat activations; neuron i occupies bits [i*OUT_WIDTH +: OUT_WIDTH].
- nrn_outvalid  in  NUM_NEURONS  per-neuron outvalid pulses.
- out_data  out  OUT_WIDTH  activation of the current neuron index.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  high on the beat for neuron NUM_NEURONS-1.
- out_max_idx  out  clog2(NUM_NEURONS)  arg-max index; valid whenever out_last is high.
- busy  out  1  high in any state other than LOAD.
- frame_done  out  1  one-cycle pulse after the last output handshake.
- err_timeout  out  1  sticky; cleared only by rst.

Behaviour:
- Reset: state LOAD; all counters 0; capture mask 0; capture registers 0.
- Reset outputs: in_ready=1, nrn_in_valid=0, nrn_in_data=0, out_valid=0, out_last=0, out_data=0, out_max_idx=0, busy=0, frame_done=0, err_timeout=0.
- rst mid-frame abandons the frame immediately, with no partial output.
- FSM LOAD:
  - in_ready=1; each in_valid&in_ready writes in_data into buffer[wr_cnt], then wr_cnt++.
  - On the handshake with wr_cnt==NUM_INPUTS-1: wr_cnt->0, go BCAST next cycle.
  - in_ready=0 in every other state; input is back-pressured, never dropped.
- FSM BCAST:
  - nrn_in_valid high for exactly NUM_INPUTS consecutive cycles, with no bubbles.
  - nrn_in_data=buffer[k] on the k-th valid cycle, k=0..NUM_INPUTS-1, aligned with valid. A synchronous buffer read needs a one-cycle prefetch, so the first valid comes 1 cycle after BCAST entry.
  - After the last valid cycle: nrn_in_valid=0, nrn_in_data holds, go WAIT.
- FSM WAIT:
  - Each nrn_outvalid[i] pulse sets mask[i] and latches slice i of nrn_out into cap[i].
  - A repeated pulse for an already-set neuron is ignored (first value kept).
  - Pulses arriving in any state other than WAIT are ignored.
  - A cycle counter starts at 0 on WAIT entry.
  - When mask is all ones: go DRAIN. This takes priority over timeout in the same cycle.
  - When the counter reaches TIMEOUT-1 with mask incomplete: set err_timeout and go DRAIN. Uncaptured cap entries read 0.
- FSM DRAIN:
  - out_valid=1 and out_data=cap[j], j from 0.
  - j advances only on out_valid&out_ready; out_data is stable while stalled.
  - out_last=(j==NUM_NEURONS-1).
  - On the last handshake: frame_done pulses the next cycle; mask and j clear; return to LOAD.
- Arg-max:
  - Unsigned compare over cap[], computed once at DRAIN entry and registered.
  - Ties resolve to the lowest index. If all entries are 0, out_max_idx=0.
- Frame latency, last input handshake to first out_valid:
  - 1 (BCAST entry) + 1 (prefetch) + NUM_INPUTS + neuron latency + 1 (capture) + 1 (DRAIN entry).
  - Neuron latency is 4 cycles for this neuron type; benches model it, not hard-code it.
- Widths: all counters are clog2(max)+1 bits. Counters never wrap, because every terminal compare is equality on the final index.

Test Plan:
- Basic frame (NUM_INPUTS=4, NUM_NEURONS=3, behavioural neuron model):
  - Stimulus: inputs 1,2,3,4 with in_valid held high.
  - Required: nrn_in_valid high exactly 4 contiguous cycles carrying 1,2,3,4.
  - Required: outputs cap=[0x20,0x80,0x40] streamed in order; out_last on beat 2; out_max_idx=1; frame_done 1 pulse.
- Input gaps: in_valid toggles 1,0,1,0,...
  - Required: the broadcast is still 4 contiguous valid cycles with no bubbles, and in_ready=0 throughout BCAST/WAIT/DRAIN.
- Output back-pressure: out_ready low for 5 cycles on beat 1.
  - Required: out_data holds 0x80 and out_valid stays 1 throughout; no beat is lost or duplicated.
- Skewed and duplicate outvalid: neuron 2 pulses 3 cycles after neurons 0/1; neuron 0 pulses twice with 0x11 then 0x55.
  - Required: DRAIN waits for neuron 2; beat 0 outputs 0x11.
- Timeout (TIMEOUT=16): neuron 1 never pulses.
  - Required: err_timeout=1 on WAIT cycle 16; beat 1 outputs 0; err_timeout stays set through the next frame; only rst clears it.
- Reset mid-BCAST: assert rst on broadcast cycle 2.
  - Required: next cycle nrn_in_valid=0, in_ready=1, busy=0.
  - Required: a fresh 4-input frame afterwards completes normally, with ties [0x40,0x40,0x10] giving out_max_idx=0.

Source files
------------

// File: rtl/elm_layer_sched.sv
// elm_layer_sched: buffers one input feature frame, broadcasts it to a layer
// of neurons as a single gap-free burst, collects every neuron's activation,
// then streams the activations out with the arg-max index on the last beat.
module elm_layer_sched #(
    parameter int DATA_WIDTH  = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int NUM_INPUTS  = 128,
    parameter int NUM_NEURONS = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            nrn_in_data,
    output logic                             nrn_in_valid,
    input  logic [NUM_NEURONS*OUT_WIDTH-1:0] nrn_out,
    input  logic [NUM_NEURONS-1:0]           nrn_outvalid,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic [$clog2(NUM_NEURONS)-1:0]   out_max_idx,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             err_timeout
);
    localparam int AW = $clog2(NUM_INPUTS);
    localparam int CW = $clog2(NUM_INPUTS) + 1;
    localparam int IW = $clog2(NUM_NEURONS);
    localparam int NW = $clog2(NUM_NEURONS) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] IN_LAST  = CW'(NUM_INPUTS - 1);
    localparam logic [CW-1:0] IN_END   = CW'(NUM_INPUTS);
    localparam logic [NW-1:0] NRN_LAST = NW'(NUM_NEURONS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_BCAST = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state_r, state_s;
    logic                                  timeout_s;
    logic [DATA_WIDTH-1:0]                 buf_mem [NUM_INPUTS];
    logic [CW-1:0]                         wr_cnt_r, bc_cnt_r;
    logic [TW-1:0]                         tmo_cnt_r;
    logic [NW-1:0]                         j_r, j_nxt_s;
    logic [DATA_WIDTH-1:0]                 rd_data_r, nrn_in_data_r;
    logic                                  nrn_in_valid_r, in_ready_r, busy_r;
    logic [NUM_NEURONS-1:0]                mask_r;
    logic [NUM_NEURONS-1:0][OUT_WIDTH-1:0] cap_r;
    logic [OUT_WIDTH-1:0]                  out_data_r;
    logic                                  out_valid_r, out_last_r, frame_done_r, err_timeout_r;
    logic [IW-1:0]                         out_max_idx_r, argmax_s;
    logic                                  in_fire_s, out_fire_s, cap_en_s, drain_entry_s, drain_done_s;

    // Unsigned arg-max over the captured activations; strict compare keeps the lowest index on ties.
    function automatic logic [IW-1:0] argmax_f(input logic [NUM_NEURONS-1:0][OUT_WIDTH-1:0] vals);
        logic [IW-1:0]        idx;
        logic [OUT_WIDTH-1:0] best;
        idx  = '0;
        best = vals[0];
        for (int i = 1; i < NUM_NEURONS; i++) begin
            if (vals[i] > best) begin
                best = vals[i];
                idx  = IW'(i);
            end else begin
                idx  = idx;
            end
        end
        return idx;
    endfunction

    assign in_fire_s     = in_valid && (state_r == S_LOAD);
    assign out_fire_s    = out_valid_r && out_ready;
    assign j_nxt_s       = j_r + NW'(1);
    assign argmax_s      = argmax_f(cap_r);
    // Captures stop on the cycle WAIT is left so the arg-max sees the final cap contents.
    assign cap_en_s      = (state_r == S_WAIT) && (state_s == S_WAIT);
    assign drain_entry_s = (state_r == S_WAIT) && (state_s == S_DRAIN);
    assign drain_done_s  = (state_r == S_DRAIN) && out_fire_s && (j_r == NRN_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a complete mask wins over the timeout in the same cycle.
    always_comb begin
        state_s   = state_r;
        timeout_s = 1'b0;
        case (state_r)
            S_LOAD: begin
                if (in_fire_s && (wr_cnt_r == IN_LAST)) state_s = S_BCAST;
                else                                     state_s = S_LOAD;
            end
            S_BCAST: begin
                if (bc_cnt_r == IN_END) state_s = S_WAIT;
                else                    state_s = S_BCAST;
            end
            S_WAIT: begin
                if (&mask_r) begin
                    state_s = S_DRAIN;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_s   = S_DRAIN;
                    timeout_s = 1'b1;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (drain_done_s) state_s = S_LOAD;
                else              state_s = S_DRAIN;
            end
            default: state_s = S_LOAD;
        endcase
    end

    // Frame buffer write port; contents need no reset since every entry is rewritten per frame.
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            buf_mem[wr_cnt_r[AW-1:0]] <= in_data;
        end
    end

    // Input write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_r <= '0;
        end else if (in_fire_s) begin
            wr_cnt_r <= (wr_cnt_r == IN_LAST) ? '0 : wr_cnt_r + CW'(1);
        end else begin
            wr_cnt_r <= wr_cnt_r;
        end
    end

    // Broadcast: bc_cnt 0 is the prefetch read, counts 1..NUM_INPUTS emit one beat each without gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            bc_cnt_r       <= '0;
            rd_data_r      <= '0;
            nrn_in_valid_r <= 1'b0;
            nrn_in_data_r  <= '0;
        end else if (state_r == S_BCAST) begin
            if (bc_cnt_r == IN_END) begin
                bc_cnt_r <= '0;
            end else begin
                bc_cnt_r  <= bc_cnt_r + CW'(1);
                rd_data_r <= buf_mem[bc_cnt_r[AW-1:0]];
            end
            if (bc_cnt_r != CW'(0)) begin
                nrn_in_valid_r <= 1'b1;
                nrn_in_data_r  <= rd_data_r;
            end else begin
                nrn_in_valid_r <= 1'b0;
            end
        end else begin
            nrn_in_valid_r <= 1'b0;
        end
    end

    // Activation capture (first pulse per neuron wins), WAIT cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r        <= '0;
            cap_r         <= '0;
            tmo_cnt_r     <= '0;
            err_timeout_r <= 1'b0;
        end else begin
            err_timeout_r <= err_timeout_r | timeout_s;
            tmo_cnt_r     <= cap_en_s ? tmo_cnt_r + TW'(1) : '0;
            if (drain_done_s) begin
                mask_r <= '0;
                cap_r  <= '0;
            end else begin
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    if (cap_en_s && nrn_outvalid[i] && !mask_r[i]) begin
                        mask_r[i] <= 1'b1;
                        cap_r[i]  <= nrn_out[i*OUT_WIDTH +: OUT_WIDTH];
                    end
                end
            end
        end
    end

    // Result stream, arg-max register and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            j_r           <= '0;
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            out_last_r    <= 1'b0;
            out_max_idx_r <= '0;
            frame_done_r  <= 1'b0;
            in_ready_r    <= 1'b1;
            busy_r        <= 1'b0;
        end else begin
            frame_done_r <= drain_done_s;
            in_ready_r   <= (state_s == S_LOAD);
            busy_r       <= (state_s != S_LOAD);
            if (drain_entry_s) begin
                j_r           <= '0;
                out_valid_r   <= 1'b1;
                out_data_r    <= cap_r[0];
                out_last_r    <= (NRN_LAST == NW'(0));
                out_max_idx_r <= argmax_s;
            end else if (drain_done_s) begin
                j_r         <= '0;
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end else if ((state_r == S_DRAIN) && out_fire_s) begin
                j_r        <= j_nxt_s;
                out_data_r <= cap_r[j_nxt_s[IW-1:0]];
                out_last_r <= (j_nxt_s == NRN_LAST);
            end else begin
                j_r <= j_r;
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign nrn_in_data  = nrn_in_data_r;
    assign nrn_in_valid = nrn_in_valid_r;
    assign out_data     = out_data_r;
    assign out_valid    = out_valid_r;
    assign out_last     = out_last_r;
    assign out_max_idx  = out_max_idx_r;
    assign busy         = busy_r;
    assign frame_done   = frame_done_r;
    assign err_timeout  = err_timeout_r;
endmodule

// File: tb/tb_elm_layer_sched.sv
// Bench for elm_layer_sched: a 3-neuron behavioural layer with 4-cycle
// latency, a per-cycle output checker against a frame-level model, and
// directed frames with hand-computed results.
`timescale 1ns/1ps
module tb_elm_layer_sched;
    localparam int DW = 16, OW = 8, N = 4, NN = 3, TMO = 16, L = 4;
    localparam int IW = $clog2(NN);

    logic              clk = 1'b0, rst = 1'b1;
    logic [DW-1:0]     in_data = '0;
    logic              in_valid = 1'b0, in_ready;
    logic [DW-1:0]     nrn_in_data;
    logic              nrn_in_valid;
    logic [NN*OW-1:0]  nrn_out = '0;
    logic [NN-1:0]     nrn_outvalid = '0;
    logic [OW-1:0]     out_data;
    logic              out_valid, out_ready = 1'b1, out_last;
    logic [IW-1:0]     out_max_idx;
    logic              busy, frame_done, err_timeout;

    elm_layer_sched #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_INPUTS(N),
                      .NUM_NEURONS(NN), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .nrn_in_data(nrn_in_data), .nrn_in_valid(nrn_in_valid), .nrn_out(nrn_out),
        .nrn_outvalid(nrn_outvalid), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_max_idx(out_max_idx),
        .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0, fire_base = -1000, hs_edge = 0;
    logic [OW-1:0] nval [NN];
    int            nskew [NN];
    bit            nen [NN];
    bit            dup_en = 1'b0;
    logic [OW-1:0] exp_cap [NN];
    int            exp_max = 0, stall_beat = -1, stall_left = 0;
    bit            err_model = 1'b0, frame_active = 1'b0, bubble = 1'b0, prev_nv = 1'b0;
    int            beat_idx = 0, first_ov = -1, done_cnt = 0;
    logic [DW-1:0] bq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Neuron layer and downstream sink: drive just after each rising edge.
    initial forever begin
        logic [NN-1:0]    nv;
        logic [NN*OW-1:0] no;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        nv = '0;
        no = {NN{8'hEE}};
        for (int i = 0; i < NN; i++) begin
            if (nen[i] && cyc == fire_base + nskew[i]) begin
                nv[i] = 1'b1;
                no[i*OW +: OW] = nval[i];
            end
        end
        if (dup_en && cyc == fire_base + 1) begin
            nv[0] = 1'b1;
            no[OW-1:0] = 8'h55;
        end
        nrn_outvalid = nv;
        nrn_out = no;
        if (out_valid && beat_idx == stall_beat && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Per-cycle checker on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_nv = 1'b0;
        end else begin
            chk("in_ready_vs_busy", {31'd0, in_ready}, {31'd0, ~busy});
            if (nrn_in_valid || out_valid) chk("in_ready_low_busy", {31'd0, in_ready}, 32'd0);
            if (nrn_in_valid) begin
                if (!prev_nv && bq.size() > 0) bubble = 1'b1;
                bq.push_back(nrn_in_data);
            end
            if (prev_nv && !nrn_in_valid) fire_base = cyc + L;
            prev_nv = nrn_in_valid;
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                if (!frame_active || beat_idx >= NN) begin
                    chk("unexpected_beat", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk($sformatf("beat%0d_data", beat_idx), {24'd0, out_data}, {24'd0, exp_cap[beat_idx]});
                    chk($sformatf("beat%0d_last", beat_idx), {31'd0, out_last}, (beat_idx == NN-1) ? 32'd1 : 32'd0);
                    chk("err_timeout_beat", {31'd0, err_timeout}, {31'd0, err_model});
                    if (out_last) chk("max_idx", 32'(out_max_idx), 32'(exp_max));
                    if (out_ready) beat_idx++;
                end
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_after_last", 32'(beat_idx), 32'(NN));
            end
        end
    end

    // Program the layer and derive the frame's expected activations and arg-max.
    task automatic config_layer(input logic [OW-1:0] v0, v1, v2, input bit e1, input int s2, input bit dup);
        nval[0] = v0; nval[1] = v1; nval[2] = v2;
        nen[0] = 1'b1; nen[1] = e1; nen[2] = 1'b1;
        nskew[0] = 0; nskew[1] = 0; nskew[2] = s2;
        dup_en = dup;
        exp_max = 0;
        for (int i = 0; i < NN; i++) exp_cap[i] = nen[i] ? nval[i] : 8'h00;
        for (int i = 1; i < NN; i++) if (exp_cap[i] > exp_cap[exp_max]) exp_max = i;
        if (!e1) err_model = 1'b1;
    endtask

    task automatic send_inputs(input logic [N-1:0][DW-1:0] d, input bit gaps);
        int k = 0, guard = 0;
        bit toggle = 1'b0;
        bq.delete();
        bubble = 1'b0;
        while (k < N && guard < 100) begin
            @(posedge clk); #1;
            if (gaps && toggle) begin
                in_valid = 1'b0;
                toggle = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data = d[k];
                toggle = 1'b1;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                k++;
                hs_edge = cyc + 1;
            end
            guard++;
        end
        chk("input_accept", 32'(k), 32'(N));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [N-1:0][DW-1:0] d, input bit gaps, input int lit_lat, input int lit_max);
        int guard = 0, exp_lat, ms = 0;
        frame_active = 1'b1;
        beat_idx = 0; first_ov = -1; done_cnt = 0;
        send_inputs(d, gaps);
        while (done_cnt == 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("frame_done_seen", 32'(done_cnt), 32'd1);
        repeat (3) @(negedge clk);
        chk("frame_done_pulses", 32'(done_cnt), 32'd1);
        chk("beats", 32'(beat_idx), 32'(NN));
        chk("bcast_len", 32'(bq.size()), 32'(N));
        for (int k = 0; k < N && k < bq.size(); k++) chk($sformatf("bcast%0d", k), 32'(bq[k]), 32'(d[k]));
        chk("bcast_bubble", {31'd0, bubble}, 32'd0);
        for (int i = 0; i < NN; i++) if (nen[i] && nskew[i] > ms) ms = nskew[i];
        exp_lat = nen[1] ? (N + L + 4 + ms) : (N + 1 + TMO);
        chk("latency", 32'(first_ov - hs_edge), 32'(exp_lat));
        chk("latency_lit", 32'(first_ov - hs_edge), 32'(lit_lat));
        chk("max_idx_lit", 32'(out_max_idx), 32'(lit_max));
        chk("err_after_frame", {31'd0, err_timeout}, {31'd0, err_model});
        frame_active = 1'b0;
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_nrn_in_valid", {31'd0, nrn_in_valid}, 32'd0);
        chk("rst_nrn_in_data", 32'(nrn_in_data), 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_max_idx", 32'(out_max_idx), 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        config_layer(8'h20, 8'h80, 8'h40, 1'b1, 0, 1'b0);
        run_frame({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 12, 1);

        config_layer(8'h05, 8'h03, 8'h07, 1'b1, 0, 1'b0);
        run_frame({16'hD00D, 16'h0BEE, 16'hCAFE, 16'h1234}, 1'b1, 12, 2);

        config_layer(8'h20, 8'h80, 8'h40, 1'b1, 0, 1'b0);
        stall_beat = 1; stall_left = 5;
        run_frame({16'd8, 16'd7, 16'd6, 16'd5}, 1'b0, 12, 1);
        chk("stall_consumed", 32'(stall_left), 32'd0);
        stall_beat = -1;

        config_layer(8'h11, 8'h22, 8'h0F, 1'b1, 3, 1'b1);
        run_frame({16'h0040, 16'h0030, 16'h0020, 16'h0010}, 1'b0, 15, 1);
        dup_en = 1'b0;

        config_layer(8'h30, 8'hAA, 8'h90, 1'b0, 0, 1'b0);
        run_frame({16'd1, 16'd1, 16'd1, 16'd1}, 1'b0, 21, 2);

        config_layer(8'h01, 8'h02, 8'h03, 1'b1, 0, 1'b0);
        run_frame({16'd9, 16'd9, 16'd9, 16'd9}, 1'b0, 12, 2);
        chk("err_sticky", {31'd0, err_timeout}, 32'd1);

        frame_active = 1'b0;
        send_inputs({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0);
        guard = 0;
        while (!nrn_in_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("bcast_started", {31'd0, nrn_in_valid}, 32'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_nrn_in_valid", {31'd0, nrn_in_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_err_clear", {31'd0, err_timeout}, 32'd0);
        err_model = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        repeat (20) @(negedge clk);

        config_layer(8'h40, 8'h40, 8'h10, 1'b1, 0, 1'b0);
        run_frame({16'd40, 16'd30, 16'd20, 16'd10}, 1'b0, 12, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
